// File: rtl/scan_sel_gen_pkg.sv
// Shared definitions for the scan select generator: channel count,
// select width and the scan FSM state type.
package scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_sel_gen_next_ch_pick.sv
// Rotating-priority channel picker. Searches the mask circularly starting
// at cur+1 (cur itself is the last candidate, so a single enabled channel
// picks itself). Driving cur with the highest index yields the lowest set
// bit, which the top module uses for the first pick out of IDLE.
module next_ch_pick
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_cur,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_any,
    output logic              o_wrapped
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_next;

    // First enabled channel after cur, wrapping modulo NUM_CH.
    always_comb begin
        w_found = 1'b0;
        w_idx   = i_cur;
        w_next  = i_cur;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = i_cur + SEL_W'(k);
            if (!w_found && i_mask[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign o_next    = w_next;
    assign o_any     = |i_mask;
    assign o_wrapped = (w_next <= i_cur);

endmodule

// File: rtl/scan_sel_gen.sv
// Round-robin select generator feeding a 2x4 decoder. Each enabled channel
// is preceded by BLANK_CYC blanking cycles and then held valid for a
// programmable dwell. All outputs are registered.
// Optional feature: define SCAN_FREEZE_EN to add the i_freeze input, which
// pauses the blank/dwell counters while high.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [NUM_CH-1:0]  i_mask,
`ifdef SCAN_FREEZE_EN
    input  logic               i_freeze,
`endif
    output logic [SEL_W-1:0]   o_sel,
    output logic               o_sel_valid,
    output logic               o_wrap,
    output logic               o_busy
);

    localparam int BLANK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYC > 0);

    // Counters hold "cycles remaining after this one"; a dwell of 0 acts as 1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == DWELL_W'(0)) ? DWELL_W'(0) : d - DWELL_W'(1);
    endfunction

    scan_state_t        r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_sel_valid;
    logic               r_wrap;
    logic               r_busy;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [BLANK_W-1:0] r_blank_cnt;

    scan_state_t        w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               w_wrap_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [BLANK_W-1:0] w_blank_nxt;
    logic               w_hold;
    logic [SEL_W-1:0]   w_pick_cur;
    logic [SEL_W-1:0]   w_pick_next;
    logic               w_pick_any;
    logic               w_pick_wrapped;

`ifdef SCAN_FREEZE_EN
    assign w_hold = i_freeze;
`else
    assign w_hold = 1'b0;
`endif

    // Out of IDLE the search starts after the top index, giving the lowest set bit.
    assign w_pick_cur = (r_state == IDLE) ? SEL_W'(NUM_CH - 1) : r_sel;

    next_ch_pick u_pick (
        .i_mask    (i_mask),
        .i_cur     (w_pick_cur),
        .o_next    (w_pick_next),
        .o_any     (w_pick_any),
        .o_wrapped (w_pick_wrapped)
    );

    // Next-state, next-select and counter update for the scan FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_wrap_nxt  = 1'b0;
        w_dwell_nxt = r_dwell_cnt;
        w_blank_nxt = r_blank_cnt;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_dwell_nxt = DWELL_W'(0);
            w_blank_nxt = BLANK_W'(0);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        w_sel_nxt = w_pick_next;
                        if (HAS_BLANK) begin
                            w_state_nxt = BLANK;
                            w_blank_nxt = BLANK_LOAD;
                        end else begin
                            w_state_nxt = DWELL;
                            w_dwell_nxt = dwell_load(i_dwell);
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                BLANK: begin
                    if (w_hold) begin
                        w_state_nxt = BLANK;
                    end else if (r_blank_cnt == BLANK_W'(0)) begin
                        w_state_nxt = DWELL;
                        w_dwell_nxt = dwell_load(i_dwell);
                    end else begin
                        w_blank_nxt = r_blank_cnt - BLANK_W'(1);
                    end
                end
                DWELL: begin
                    if (w_hold) begin
                        w_state_nxt = DWELL;
                    end else if (r_dwell_cnt != DWELL_W'(0)) begin
                        w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                    end else if (!w_pick_any) begin
                        // Every channel masked off: finish the scan quietly.
                        w_state_nxt = IDLE;
                    end else begin
                        w_sel_nxt  = w_pick_next;
                        w_wrap_nxt = w_pick_wrapped;
                        if (HAS_BLANK) begin
                            w_state_nxt = BLANK;
                            w_blank_nxt = BLANK_LOAD;
                        end else begin
                            w_state_nxt = DWELL;
                            w_dwell_nxt = dwell_load(i_dwell);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_sel       <= SEL_W'(0);
            r_sel_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_dwell_cnt <= DWELL_W'(0);
            r_blank_cnt <= BLANK_W'(0);
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_valid <= (w_state_nxt == DWELL);
            r_wrap      <= w_wrap_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_dwell_cnt <= w_dwell_nxt;
            r_blank_cnt <= w_blank_nxt;
        end
    end

    assign o_sel       = r_sel;
    assign o_sel_valid = r_sel_valid;
    assign o_wrap      = r_wrap;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen: table-driven directed vectors,
// hand-written corner sequences and a randomized run against a reference
// model. Define SCAN_FREEZE_EN to also exercise the freeze input.
module tb_scan_sel_gen;

    localparam int DWELL_W   = 16;
    localparam int BLANK_CYC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [3:0]   mask;
    logic [15:0]  dwell;
    logic         freeze;
    logic [1:0]   sel;
    logic         sel_valid;
    logic         wrap;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: expected outputs plus cycles left in the current phase.
    logic [1:0] m_sel   = 2'd0;
    logic       m_valid = 1'b0;
    logic       m_wrap  = 1'b0;
    logic       m_busy  = 1'b0;
    int         m_left  = 0;

    typedef struct {
        logic        en;
        logic [3:0]  mask;
        logic [15:0] dwell;
        logic [1:0]  sel;
        logic        valid;
        logic        wrap;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    scan_sel_gen #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_dwell     (dwell),
        .i_mask      (mask),
`ifdef SCAN_FREEZE_EN
        .i_freeze    (freeze),
`endif
        .o_sel       (sel),
        .o_sel_valid (sel_valid),
        .o_wrap      (wrap),
        .o_busy      (busy)
    );

    function automatic logic [1:0] lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [1:0] circ_next(input logic [3:0] m, input logic [1:0] s);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (int'(s) + k) % 4;
            if (m[c]) return 2'(c);
        end
        return s;
    endfunction

    function automatic int eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    function automatic vec_t mk(input logic e, input logic [3:0] m, input logic [15:0] d,
                                input logic [1:0] s, input logic v, input logic w, input logic b);
        vec_t r;
        r.en = e; r.mask = m; r.dwell = d; r.sel = s; r.valid = v; r.wrap = w; r.busy = b;
        return r;
    endfunction

    // Reference model step on each clock edge, from the behavioural rules.
    always @(posedge clk) begin
        if (rst) begin
            m_sel <= 2'd0; m_valid <= 1'b0; m_wrap <= 1'b0; m_busy <= 1'b0; m_left <= 0;
        end else if (!en) begin
            m_valid <= 1'b0; m_wrap <= 1'b0; m_busy <= 1'b0; m_left <= 0;
        end else if (!m_busy) begin
            m_wrap <= 1'b0;
            if (mask != 4'd0) begin
                m_sel  <= lowest(mask);
                m_busy <= 1'b1;
                if (BLANK_CYC > 0) begin m_valid <= 1'b0; m_left <= BLANK_CYC; end
                else begin m_valid <= 1'b1; m_left <= eff(dwell); end
            end
        end else if (freeze) begin
            m_wrap <= 1'b0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
            m_wrap <= 1'b0;
        end else if (!m_valid) begin
            m_valid <= 1'b1; m_left <= eff(dwell); m_wrap <= 1'b0;
        end else if (mask == 4'd0) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_wrap <= 1'b0;
        end else begin
            m_wrap <= (circ_next(mask, m_sel) <= m_sel);
            m_sel  <= circ_next(mask, m_sel);
            m_busy <= 1'b1;
            if (BLANK_CYC > 0) begin m_valid <= 1'b0; m_left <= BLANK_CYC; end
            else begin m_valid <= 1'b1; m_left <= eff(dwell); end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: outputs sampled 2 time units after the edge and held against the model.
    task automatic tick();
        @(posedge clk);
        #2;
        check("model_sel",   32'(sel),       32'(m_sel));
        check("model_valid", 32'(sel_valid), 32'(m_valid));
        check("model_wrap",  32'(wrap),      32'(m_wrap));
        check("model_busy",  32'(busy),      32'(m_busy));
    endtask

    initial begin
        int wraps;
        int vcount;
        rst = 1'b1; en = 1'b0; mask = 4'd0; dwell = 16'd0; freeze = 1'b0;
        tick();
        tick();
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_valid", 32'(sel_valid), 32'd0);
        check("rst_wrap",  32'(wrap),      32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // Full round robin, mask 1111, dwell 3.
        for (int i = 0; i < 2; i++)  tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'd0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++)  tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'd0, 1'b1, 1'b0, 1'b1));
        for (int c = 1; c < 4; c++) begin
            for (int i = 0; i < 2; i++) tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'(c), 1'b0, 1'b0, 1'b1));
            for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'(c), 1'b1, 1'b0, 1'b1));
        end
        tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'd0, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hF, 16'd3, 2'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'hF, 16'd3, 2'd0, 1'b0, 1'b0, 1'b0));
        // Mask 1010, dwell 1: alternates 1,3 with wrap on 3->1.
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd3, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd3, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd3, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd1, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 4'hA, 16'd1, 2'd3, 1'b0, 1'b0, 1'b1));
        // en dropped mid-blank: sel holds 3.
        tbl.push_back(mk(1'b0, 4'hA, 16'd1, 2'd3, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            en = tbl[i].en; mask = tbl[i].mask; dwell = tbl[i].dwell;
            tick();
            check("tbl_sel",   32'(sel),       32'(tbl[i].sel));
            check("tbl_valid", 32'(sel_valid), 32'(tbl[i].valid));
            check("tbl_wrap",  32'(wrap),      32'(tbl[i].wrap));
            check("tbl_busy",  32'(busy),      32'(tbl[i].busy));
        end

        // Single channel: sel stays 2, wrap every 4 cycles.
        en = 1'b1; mask = 4'b0100; dwell = 16'd2; wraps = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("single_sel", 32'(sel), 32'd2);
            if (wrap) wraps++;
        end
        check("single_wraps", 32'(wraps), 32'd2);

        // Mask cleared mid-dwell on channel 1: dwell completes, then IDLE.
        en = 1'b0; tick();
        en = 1'b1; mask = 4'hF; dwell = 16'd3;
        repeat (8) tick();
        check("p4_sel",   32'(sel),       32'd1);
        check("p4_valid", 32'(sel_valid), 32'd1);
        mask = 4'd0;
        tick(); tick();
        check("p4_valid_end", 32'(sel_valid), 32'd1);
        tick();
        check("p4_idle_busy",  32'(busy),      32'd0);
        check("p4_idle_valid", 32'(sel_valid), 32'd0);
        check("p4_idle_wrap",  32'(wrap),      32'd0);
        check("p4_idle_sel",   32'(sel),       32'd1);

        // Reset mid-blank forces sel back to 0.
        en = 1'b0; tick();
        en = 1'b1; mask = 4'b1000; dwell = 16'd3;
        tick();
        check("p5_blank_sel",  32'(sel),  32'd3);
        check("p5_blank_busy", 32'(busy), 32'd1);
        rst = 1'b1; en = 1'b0;
        tick();
        check("p5_rst_sel",   32'(sel),       32'd0);
        check("p5_rst_valid", 32'(sel_valid), 32'd0);
        check("p5_rst_busy",  32'(busy),      32'd0);
        rst = 1'b0;

        // dwell = 0 behaves as a one-cycle dwell.
        en = 1'b1; mask = 4'b0001; dwell = 16'd0;
        tick(); tick(); tick();
        check("d0_valid", 32'(sel_valid), 32'd1);
        tick();
        check("d0_valid_end", 32'(sel_valid), 32'd0);
        check("d0_wrap",      32'(wrap),      32'd1);
        check("d0_sel",       32'(sel),       32'd0);

`ifdef SCAN_FREEZE_EN
        // Five frozen cycles stretch a 3-cycle dwell to 8 valid cycles.
        en = 1'b0; tick();
        en = 1'b1; mask = 4'b0001; dwell = 16'd3; vcount = 0;
        for (int i = 0; i < 12; i++) begin
            freeze = (i >= 3 && i <= 7);
            tick();
            if (sel_valid) vcount++;
        end
        freeze = 1'b0;
        check("freeze_valid_len", 32'(vcount), 32'd8);
`endif

        // Randomized run against the model.
        en = 1'b0; tick();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            dwell = 16'($urandom_range(0, 4));
`ifdef SCAN_FREEZE_EN
            freeze = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
